pair_reduce: RTL and testbench
==============================

PAIR_REDUCE -- requirements
Module: pair_reduce

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the signed data width of all argument, data and result ports.
REQ-002 SHALL have ports: _clock input 1, sole clock; all logic on posedge. _reset input 1, one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports: arg0, arg1, arg2 input WIDTH signed, generator arguments captured on _start.
REQ-004 SHALL have ports: _start input 1, capture args and begin; _ready input 1, caller ready for the result; _valid output 1, result valid; _done output 1, block finished.
REQ-005 SHALL have ports: _0, _1, _2 output WIDTH signed: count of pairs, sum of _in_0, sum of _in_1.
REQ-006 SHALL have upstream ports: _in_arg0.._in_arg2 output WIDTH; _in_start output 1; _in_ready output 1; _in_valid input 1; _in_done input 1; _in_0, _in_1 input WIDTH signed.

Function
REQ-007 SHALL act as the caller end of the ready/valid generator protocol: drive the upstream generator, consume every (_in_0,_in_1) tuple, and yield one reduction tuple.
REQ-008 SHALL implement states IDLE, CALL, COLLECT, EMIT, DONE.
REQ-009 _start high at edge t SHALL register args onto _in_arg0..2, set _in_start=1 and _in_ready=0, clear accumulators, drop _valid, and enter CALL; this takes effect from any state.
REQ-010 CALL SHALL deassert _in_start after exactly one cycle, assert _in_ready, and enter COLLECT.
REQ-011 A pair SHALL be accepted only on an edge where _in_ready && _in_valid; on acceptance: count+1, sum0+=_in_0, sum1+=_in_1.
REQ-012 Sums and count SHALL wrap modulo 2^WIDTH, with no saturation and no overflow flag.
REQ-013 _in_valid low in COLLECT SHALL hold all accumulators; gaps of any length are legal.
REQ-014 _in_done high in COLLECT SHALL, on that edge, accept a simultaneously valid pair, then load _0/_1/_2 from the final totals (including that pair), set _valid=1, drop _in_ready, and enter EMIT.
REQ-015 EMIT SHALL hold _valid and outputs stable until _ready is sampled high.
REQ-016 On that edge, EMIT SHALL set _valid=0 and enter DONE.
REQ-017 DONE SHALL assert _done every cycle until _start.
REQ-018 An empty stream (_in_done with no prior accept) SHALL yield _0=_1=_2=0.
REQ-019 Latency SHALL be: _start edge to _in_start visible = 1 cycle; _in_done edge to _valid visible = 1 cycle; _ready edge to _done visible = 1 cycle.
REQ-020 IDLE SHALL drive all outputs low and ignore _in_*.

Reset
REQ-021 _reset low at an edge without _start SHALL set state DONE and set _valid, _in_start and _in_ready to 0.
REQ-022 Reset SHALL clear the accumulators and _0.._2 to 0, and assert _done from the next cycle.
REQ-023 _start SHALL take precedence over a simultaneous _reset low.
REQ-024 Reset mid-COLLECT SHALL discard partial totals; the upstream is left unstarted.

Configuration
REQ-025 Macro PAIR_REDUCE_MINMAX_EN defined SHALL add outputs _3 (max of _in_0) and _4 (min of _in_0), WIDTH signed, updated on each accept.
REQ-026 With PAIR_REDUCE_MINMAX_EN, on an empty stream _3 SHALL be the most-negative value and _4 the most-positive value.
REQ-027 Macro PAIR_REDUCE_MINMAX_EN undefined SHALL remove those ports and registers entirely.

Structure
REQ-028 The state enum and the result-index constants SHALL live in the shared package pair_reduce_pkg.
REQ-029 The accumulator SHALL be one sub-module, pair_accum: clear, accept, wrap-add, and optional min/max; the FSM stays in pair_reduce.

Verification
REQ-030 Scenario: upstream model emits (0,0),(2,2),(4,4),(6,6),(8,8) then done -> _0=5, _1=20, _2=20 (MINMAX: _3=8, _4=0), and _done follows the accepted result.
REQ-031 Scenario: upstream emits done immediately (args 5,5,1) -> one result 0,0,0 (MINMAX: _3=0x80000000, _4=0x7FFFFFFF).
REQ-032 Scenario: _ready held low 4 cycles after _valid -> outputs stable and _done low throughout; _ready high -> _valid falls and _done rises next cycle.
REQ-033 Scenario: upstream inserts 3-cycle _in_valid gaps and presents last pair with _in_done in the same cycle -> count and sums include that pair exactly once.
REQ-034 Scenario: pairs (0x7FFFFFFF,1),(1,-2) -> _1=0x80000000, _2=-1, no flag.
REQ-035 Scenario: _reset low after 2 accepts, then _start with args (0,10,2) -> _in_start pulses once and the result is 5,20,20, with no stale totals.

Source files
------------

// File: rtl/pair_reduce_pkg.sv
// pair_reduce_pkg: FSM states and result-slot indices; PAIR_REDUCE_MINMAX_EN adds the max/min slots.
package pair_reduce_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALL    = 3'd1,
        COLLECT = 3'd2,
        EMIT    = 3'd3,
        DONE    = 3'd4
    } state_t;
    localparam int RES_COUNT = 0;
    localparam int RES_SUM0  = 1;
    localparam int RES_SUM1  = 2;
`ifdef PAIR_REDUCE_MINMAX_EN
    localparam int RES_MAX = 3;
    localparam int RES_MIN = 4;
    localparam int N_RES   = 5;
`else
    localparam int N_RES   = 3;
`endif
endpackage

// File: rtl/pair_accum.sv
// pair_accum: wrapping count/sum accumulator with look-ahead totals; PAIR_REDUCE_MINMAX_EN adds max/min of in_0.
module pair_accum
    import pair_reduce_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    clear,
    input  logic                    accept,
    input  logic signed [WIDTH-1:0] in_0,
    input  logic signed [WIDTH-1:0] in_1,
    output logic signed [WIDTH-1:0] totals [N_RES]
);
    logic signed [WIDTH-1:0] acc [N_RES];
    // totals already include the pair accepted on this edge, so the FSM can latch final results directly
    always_comb begin
        totals[RES_COUNT] = acc[RES_COUNT] + WIDTH'(accept);
        totals[RES_SUM0]  = accept ? acc[RES_SUM0] + in_0 : acc[RES_SUM0];
        totals[RES_SUM1]  = accept ? acc[RES_SUM1] + in_1 : acc[RES_SUM1];
`ifdef PAIR_REDUCE_MINMAX_EN
        totals[RES_MAX]   = (accept && in_0 > acc[RES_MAX]) ? in_0 : acc[RES_MAX];
        totals[RES_MIN]   = (accept && in_0 < acc[RES_MIN]) ? in_0 : acc[RES_MIN];
`endif
    end
    always_ff @(posedge _clock) begin
        if (clear) begin
            acc[RES_COUNT] <= '0;
            acc[RES_SUM0]  <= '0;
            acc[RES_SUM1]  <= '0;
`ifdef PAIR_REDUCE_MINMAX_EN
            acc[RES_MAX]   <= {1'b1, {(WIDTH-1){1'b0}}};
            acc[RES_MIN]   <= {1'b0, {(WIDTH-1){1'b1}}};
`endif
        end else begin
            acc <= totals;
        end
    end
endmodule

// File: rtl/pair_reduce.sv
// pair_reduce: drives an upstream ready/valid generator and reduces its pairs to count/sum0/sum1 (PAIR_REDUCE_MINMAX_EN adds _3/_4).
module pair_reduce
    import pair_reduce_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic signed [WIDTH-1:0] arg0,
    input  logic signed [WIDTH-1:0] arg1,
    input  logic signed [WIDTH-1:0] arg2,
    input  logic                    _start,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
    output logic signed [WIDTH-1:0] _0,
    output logic signed [WIDTH-1:0] _1,
    output logic signed [WIDTH-1:0] _2,
`ifdef PAIR_REDUCE_MINMAX_EN
    output logic signed [WIDTH-1:0] _3,
    output logic signed [WIDTH-1:0] _4,
`endif
    output logic        [WIDTH-1:0] _in_arg0,
    output logic        [WIDTH-1:0] _in_arg1,
    output logic        [WIDTH-1:0] _in_arg2,
    output logic                    _in_start,
    output logic                    _in_ready,
    input  logic                    _in_valid,
    input  logic                    _in_done,
    input  logic signed [WIDTH-1:0] _in_0,
    input  logic signed [WIDTH-1:0] _in_1
);
    state_t state;
    logic clear, accept;
    logic signed [WIDTH-1:0] totals [N_RES];
    assign clear  = _start || !_reset;
    assign accept = !clear && state == COLLECT && _in_ready && _in_valid;
    assign _done  = state == DONE;
    pair_accum #(.WIDTH(WIDTH)) u_accum (
        ._clock (_clock),
        .clear  (clear),
        .accept (accept),
        .in_0   (_in_0),
        .in_1   (_in_1),
        .totals (totals)
    );
    // _start outranks _reset so a caller can restart straight out of a reset cycle
    always_ff @(posedge _clock) begin
        if (_start) begin
            _in_arg0  <= arg0;
            _in_arg1  <= arg1;
            _in_arg2  <= arg2;
            _in_start <= 1'b1;
            _in_ready <= 1'b0;
            _valid    <= 1'b0;
            state     <= CALL;
        end else if (!_reset) begin
            _in_start <= 1'b0;
            _in_ready <= 1'b0;
            _valid    <= 1'b0;
            _0        <= '0;
            _1        <= '0;
            _2        <= '0;
`ifdef PAIR_REDUCE_MINMAX_EN
            _3        <= '0;
            _4        <= '0;
`endif
            state     <= DONE;
        end else begin
            case (state)
                CALL: begin
                    _in_start <= 1'b0;
                    _in_ready <= 1'b1;
                    state     <= COLLECT;
                end
                COLLECT: if (_in_done) begin
                    _0        <= totals[RES_COUNT];
                    _1        <= totals[RES_SUM0];
                    _2        <= totals[RES_SUM1];
`ifdef PAIR_REDUCE_MINMAX_EN
                    _3        <= totals[RES_MAX];
                    _4        <= totals[RES_MIN];
`endif
                    _valid    <= 1'b1;
                    _in_ready <= 1'b0;
                    state     <= EMIT;
                end
                EMIT: if (_ready) begin
                    _valid <= 1'b0;
                    state  <= DONE;
                end
                DONE: state <= DONE;
                default: begin
                    _in_start <= 1'b0;
                    _in_ready <= 1'b0;
                    _valid    <= 1'b0;
                    _0        <= '0;
                    _1        <= '0;
                    _2        <= '0;
`ifdef PAIR_REDUCE_MINMAX_EN
                    _3        <= '0;
                    _4        <= '0;
`endif
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pair_reduce.sv
// tb_pair_reduce: randomized upstream generator plus a list-based reference model for pair_reduce (honours PAIR_REDUCE_MINMAX_EN).
module tb_pair_reduce;
    localparam int W = 32;
    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } pair_t;
    logic clk = 1'b0;
    logic rst_n, start, ready, in_valid, in_done;
    logic signed [W-1:0] a0, a1, a2, in0, in1, r0, r1, r2;
`ifdef PAIR_REDUCE_MINMAX_EN
    logic signed [W-1:0] r3, r4;
`endif
    logic valid, done, in_start, in_ready;
    logic [W-1:0] ia0, ia1, ia2;
    pair_t pairs[$];
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    pair_reduce #(.WIDTH(W)) dut (
        ._clock    (clk),
        ._reset    (rst_n),
        .arg0      (a0),
        .arg1      (a1),
        .arg2      (a2),
        ._start    (start),
        ._ready    (ready),
        ._valid    (valid),
        ._done     (done),
        ._0        (r0),
        ._1        (r1),
        ._2        (r2),
`ifdef PAIR_REDUCE_MINMAX_EN
        ._3        (r3),
        ._4        (r4),
`endif
        ._in_arg0  (ia0),
        ._in_arg1  (ia1),
        ._in_arg2  (ia2),
        ._in_start (in_start),
        ._in_ready (in_ready),
        ._in_valid (in_valid),
        ._in_done  (in_done),
        ._in_0     (in0),
        ._in_1     (in1)
    );
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic fill_range(input int lo, input int hi, input int stride);
        pairs.delete();
        for (int i = lo; i < hi; i += stride) pairs.push_back('{i, i});
    endtask
    task automatic fill_random(input int n);
        pairs.delete();
        for (int i = 0; i < n; i++) pairs.push_back('{$urandom, $urandom});
    endtask
    // One full call: start, stream every queued pair with gaps, then check the reduction and handshake.
    task automatic run(input int x0, input int x1, input int x2, input int gap, input bit merge,
                       input int hold, input bit rst_too);
        logic [W-1:0] c = '0;
        logic [W-1:0] s0 = '0;
        logic [W-1:0] s1 = '0;
        logic signed [W-1:0] mx = {1'b1, {(W-1){1'b0}}};
        logic signed [W-1:0] mn = {1'b0, {(W-1){1'b1}}};
        foreach (pairs[i]) begin
            c  += 1;
            s0 += pairs[i].x;
            s1 += pairs[i].y;
            if ($signed(pairs[i].x) > mx) mx = pairs[i].x;
            if ($signed(pairs[i].x) < mn) mn = pairs[i].x;
        end
        a0 = x0;
        a1 = x1;
        a2 = x2;
        start = 1'b1;
        if (rst_too) rst_n = 1'b0;
        step;
        start = 1'b0;
        rst_n = 1'b1;
        check("in_start_on", in_start, 1);
        check("in_ready_call", in_ready, 0);
        check("valid_call", valid, 0);
        check("done_call", done, 0);
        check("in_arg0", ia0, x0);
        check("in_arg1", ia1, x1);
        check("in_arg2", ia2, x2);
        step;
        check("in_start_off", in_start, 0);
        check("in_ready_on", in_ready, 1);
        foreach (pairs[i]) begin
            repeat (gap) step;
            in_valid = 1'b1;
            in0 = pairs[i].x;
            in1 = pairs[i].y;
            in_done = merge && i == pairs.size() - 1;
            step;
            in_valid = 1'b0;
            in_done = 1'b0;
        end
        if (!(merge && pairs.size() > 0)) begin
            repeat (gap) step;
            in_done = 1'b1;
            step;
            in_done = 1'b0;
        end
        check("valid_up", valid, 1);
        check("in_ready_drop", in_ready, 0);
        check("done_emit", done, 0);
        check("count", r0, c);
        check("sum0", r1, s0);
        check("sum1", r2, s1);
`ifdef PAIR_REDUCE_MINMAX_EN
        check("max", r3, mx);
        check("min", r4, mn);
`endif
        repeat (hold) begin
            step;
            check("valid_hold", valid, 1);
            check("done_hold", done, 0);
            check("count_hold", r0, c);
            check("sum0_hold", r1, s0);
            check("sum1_hold", r2, s1);
        end
        ready = 1'b1;
        step;
        ready = 1'b0;
        check("valid_fall", valid, 0);
        check("done_rise", done, 1);
        step;
        check("done_stay", done, 1);
    endtask
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        in_valid = 1'b0;
        in_done = 1'b0;
        in0 = '0;
        in1 = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        step;
        step;
        check("rst_done", done, 1);
        check("rst_valid", valid, 0);
        check("rst_in_start", in_start, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_0", r0, 0);
        check("rst_1", r1, 0);
        check("rst_2", r2, 0);
        rst_n = 1'b1;
        fill_range(0, 10, 2);
        run(0, 10, 2, 0, 0, 1, 0);
        fill_range(5, 5, 1);
        run(5, 5, 1, 1, 0, 0, 0);
        fill_range(0, 10, 2);
        run(0, 10, 2, 0, 0, 4, 0);
        fill_random(4);
        run(1, 2, 3, 3, 1, 0, 0);
        pairs.delete();
        pairs.push_back('{32'h7FFF_FFFF, 32'h0000_0001});
        pairs.push_back('{32'h0000_0001, 32'hFFFF_FFFE});
        run(0, 0, 0, 0, 0, 0, 0);
        a0 = 7;
        a1 = 8;
        a2 = 9;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in0 = 100;
            in1 = 200;
            step;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        check("midrst_done", done, 1);
        check("midrst_valid", valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_0", r0, 0);
        step;
        check("midrst_no_start", in_start, 0);
        fill_range(0, 10, 2);
        run(0, 10, 2, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            fill_random($urandom_range(0, 6));
            run($urandom, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), k == 3);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
